// File: rtl/sd_spi_if.sv
// sd_spi_if: SPI-mode SD link pins plus card-side command observation signals.
interface sd_spi_if;
  logic        sd_clk;
  logic        sd_cs;
  logic        sd_mosi;
  logic        sd_miso;
  logic        card_ready;
  logic        cmd_valid;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  modport slave (input sd_clk, sd_cs, sd_mosi, output sd_miso, card_ready, cmd_valid, cmd_index, cmd_arg);
  modport master (output sd_clk, sd_cs, sd_mosi, input sd_miso, card_ready, cmd_valid, cmd_index, cmd_arg);
endinterface

// File: rtl/sd_spi_responder.sv
// sd_spi_responder: oversampled SPI-mode SD card model answering CMD0, CMD8, CMD55 and ACMD41.
module sd_spi_responder #(
  parameter int         ACMD41_BUSY_CNT = 2,
  parameter int         NCR_BYTES       = 1,
  parameter logic [3:0] VHS_ACCEPT      = 4'h1
) (
  input  logic     clk,
  input  logic     reset,
  sd_spi_if.slave  bus
);
  localparam logic [6:0] NCR_LAST = 7'(NCR_BYTES * 8 - 1);
  localparam logic [7:0] BUSY_MAX = 8'(ACMD41_BUSY_CNT);
  typedef enum logic [1:0] {L_IDLE, L_RX, L_NCR, L_TX} link_t;
  typedef enum logic [1:0] {C_NOINIT, C_IDLE, C_READY} card_t;
  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    c = '0;
    for (int k = 39; k >= 0; k--) c = {c[5:0], 1'b0} ^ ((d[k] ^ c[6]) ? 7'h09 : 7'h00);
    return c;
  endfunction
  link_t       r_link, w_link;
  card_t       r_card, w_card;
  logic [1:0]  r_sclk_s, r_cs_s, r_mosi_s;
  logic        r_sclk_d, r_miso, r_app, r_valid, r_tx_long;
  logic [46:0] r_shift;
  logic [6:0]  r_cnt;
  logic [39:0] r_tx;
  logic [7:0]  r_busy;
  logic [5:0]  r_idx;
  logic [31:0] r_arg;
  logic        w_rise, w_fall, w_cs, w_mosi, w_done, w_good, w_i, w_crc_bad;
  logic        w_resp, w_long, w_busy_inc;
  logic [47:0] w_frame;
  logic [5:0]  w_idx;
  logic [31:0] w_arg;
  logic [39:0] w_tx;
  assign w_rise    = r_sclk_s[1] & ~r_sclk_d;
  assign w_fall    = ~r_sclk_s[1] & r_sclk_d;
  assign w_cs      = r_cs_s[1];
  assign w_mosi    = r_mosi_s[1];
  assign w_frame   = {r_shift, w_mosi};
  assign w_idx     = w_frame[45:40];
  assign w_arg     = w_frame[39:8];
  assign w_good    = w_frame[46] & w_frame[0];
  assign w_done    = (r_link == L_RX) && w_rise && !w_cs && (r_cnt == 7'd47);
  assign w_i       = r_card != C_READY;
  assign w_crc_bad = (w_idx == 6'd0 || w_idx == 6'd8) && (crc7(w_frame[47:8]) != w_frame[7:1]);
  always_comb begin
    w_link     = r_link;
    w_card     = r_card;
    w_tx       = '1;
    w_long     = 1'b0;
    w_busy_inc = 1'b0;
    w_resp     = 1'b0;
    if (w_cs) w_link = L_IDLE;
    else if (r_link == L_IDLE) w_link = (w_rise && !w_mosi) ? L_RX : L_IDLE;
    else if (r_link == L_NCR) w_link = (w_fall && r_cnt == NCR_LAST) ? L_TX : L_NCR;
    else if (r_link == L_TX) w_link = (w_fall && r_cnt == (r_tx_long ? 7'd40 : 7'd8)) ? L_IDLE : L_TX;
    else if (w_done) begin
      w_link = L_IDLE;
      if (w_good) begin
        w_resp = 1'b1;
        if (w_crc_bad) w_tx[39:32] = {4'h0, 3'b100, w_i};
        else if (r_card == C_NOINIT && w_idx != 6'd0) w_resp = 1'b0;
        else if (w_idx == 6'd0) begin
          w_tx[39:32] = 8'h01;
          w_card      = C_IDLE;
        end else if (w_idx == 6'd8) begin
          w_long = 1'b1;
          w_tx   = {8'h01, 16'h0000, 4'h0, (w_arg[11:8] == VHS_ACCEPT) ? VHS_ACCEPT : 4'h0, w_arg[7:0]};
        end else if (w_idx == 6'd55) w_tx[39:32] = {7'h00, w_i};
        else if (w_idx == 6'd41 && r_app) begin
          w_busy_inc  = r_busy < BUSY_MAX;
          w_tx[39:32] = {7'h00, w_busy_inc};
          w_card      = w_busy_inc ? r_card : C_READY;
        end else w_tx[39:32] = {5'h00, 2'b10, w_i};
        w_link = w_resp ? L_NCR : L_IDLE;
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_link    <= L_IDLE;
      r_card    <= C_NOINIT;
      r_sclk_s  <= 2'b00;
      r_cs_s    <= 2'b11;
      r_mosi_s  <= 2'b11;
      r_sclk_d  <= 1'b0;
      r_miso    <= 1'b1;
      r_app     <= 1'b0;
      r_valid   <= 1'b0;
      r_tx_long <= 1'b0;
      r_shift   <= '0;
      r_cnt     <= '0;
      r_tx      <= '1;
      r_busy    <= '0;
      r_idx     <= '0;
      r_arg     <= '0;
    end else begin
      r_sclk_s <= {r_sclk_s[0], bus.sd_clk};
      r_cs_s   <= {r_cs_s[0], bus.sd_cs};
      r_mosi_s <= {r_mosi_s[0], bus.sd_mosi};
      r_sclk_d <= r_sclk_s[1];
      r_link   <= w_link;
      r_card   <= w_card;
      r_valid  <= w_done && w_good;
      if (w_done && w_good) begin
        r_idx     <= w_idx;
        r_arg     <= w_arg;
        r_app     <= w_idx == 6'd55;
        r_tx      <= w_tx;
        r_tx_long <= w_long;
        r_busy    <= (w_idx == 6'd0 && !w_crc_bad) ? 8'h00 : r_busy + {7'h00, w_busy_inc};
      end
      if (w_cs) begin
        r_cnt  <= '0;
        r_miso <= 1'b1;
      end else if (r_link == L_IDLE && w_link == L_RX) begin
        r_shift <= {46'h0, w_mosi};
        r_cnt   <= 7'd1;
      end else if (r_link == L_RX && w_rise) begin
        r_shift <= w_frame[46:0];
        r_cnt   <= w_done ? 7'd0 : r_cnt + 7'd1;
      end else if (r_link == L_NCR && w_fall) begin
        r_miso <= 1'b1;
        r_cnt  <= (w_link == L_TX) ? 7'd0 : r_cnt + 7'd1;
      end else if (r_link == L_TX && w_fall) begin
        r_miso <= (w_link == L_IDLE) ? 1'b1 : r_tx[39];
        r_tx   <= {r_tx[38:0], 1'b1};
        r_cnt  <= (w_link == L_IDLE) ? 7'd0 : r_cnt + 7'd1;
      end
    end
  end
  assign bus.sd_miso    = r_miso;
  assign bus.card_ready = r_card == C_READY;
  assign bus.cmd_valid  = r_valid;
  assign bus.cmd_index  = r_idx;
  assign bus.cmd_arg    = r_arg;
endmodule
